// File: rtl/riscv_wb_unit.sv
// riscv_wb_unit: writeback stage between MEM and the register-file write port.
// Accepts one instruction at a time. ALU, PC+4 and CSR results are written one
// cycle after the transfer. A load waits in WAIT_MEM for its data-memory
// response, then the data is aligned and extended and written one cycle later.
//
// Handshake: an instruction moves across when in_valid && in_ready at a rising
// clock edge. in_ready is high exactly when the unit is IDLE. in_valid may stay
// high while in_ready is low; the inputs are sampled only on a transfer.
module riscv_wb_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32,
   parameter int OFF_W = $clog2(XLEN/8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_wb_src,
   input  logic              in_reg_write,
   input  logic [4:0]        in_rd,
   input  logic [XLEN-1:0]   in_alu_result,
   input  logic [XLEN-1:0]   in_pc_plus4,
   input  logic [XLEN-1:0]   in_csr_rdata,
   input  logic [2:0]        in_funct3,
   input  logic              dmem_rvalid,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic              rf_we,
   output logic [4:0]        rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              retire,
   output logic [CNT_W-1:0]  retire_count,
   output logic              busy,
   output logic              err_unexp_rsp
);

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } wb_state_e;

   localparam logic [1:0]       SRC_ALU = 2'b00;
   localparam logic [1:0]       SRC_MEM = 2'b01;
   localparam logic [1:0]       SRC_PC4 = 2'b10;
   localparam logic [1:0]       SRC_CSR = 2'b11;
   // Offset masks that select the naturally aligned half / word lane.
   localparam logic [OFF_W-1:0] H_MASK  = ~OFF_W'(1);
   localparam logic [OFF_W-1:0] W_MASK  = ~OFF_W'(3);

   wb_state_e         state_q, state_d;
   logic [4:0]        ld_rd_q, ld_rd_d;
   logic              ld_we_q, ld_we_d;
   logic [2:0]        ld_fn3_q, ld_fn3_d;
   logic [OFF_W-1:0]  ld_off_q, ld_off_d;
   logic              rf_we_q, rf_we_d;
   logic [4:0]        rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
   logic              retire_q, retire_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;

   logic              accept;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic [31:0]       lane_w;
   logic [XLEN-1:0]   load_data;
   logic [XLEN-1:0]   src_data;

   assign in_ready      = (state_q == IDLE);
   assign accept        = in_valid && in_ready;
   assign busy          = (state_q == WAIT_MEM);
   assign rf_we         = rf_we_q;
   assign rf_waddr      = rf_waddr_q;
   assign rf_wdata      = rf_wdata_q;
   assign retire        = retire_q;
   assign retire_count  = cnt_q;
   assign err_unexp_rsp = err_q;

   // Extract the addressed byte / half / word lanes and extend per funct3.
   always_comb begin
      lane_b    = 8'(dmem_rdata >> {ld_off_q, 3'b000});
      lane_h    = 16'(dmem_rdata >> {ld_off_q & H_MASK, 3'b000});
      lane_w    = 32'(dmem_rdata >> {ld_off_q & W_MASK, 3'b000});
      load_data = dmem_rdata;
      case (ld_fn3_q)
         3'b000:  load_data = XLEN'($signed(lane_b));
         3'b100:  load_data = XLEN'(lane_b);
         3'b001:  load_data = XLEN'($signed(lane_h));
         3'b101:  load_data = XLEN'(lane_h);
         3'b010:  load_data = (XLEN == 64) ? XLEN'($signed(lane_w)) : dmem_rdata;
         3'b110:  load_data = (XLEN == 64) ? XLEN'(lane_w) : dmem_rdata;
         default: load_data = dmem_rdata;
      endcase
   end

   // Select the non-load writeback source.
   always_comb begin
      src_data = in_alu_result;
      case (in_wb_src)
         SRC_PC4: src_data = in_pc_plus4;
         SRC_CSR: src_data = in_csr_rdata;
         default: src_data = in_alu_result;
      endcase
   end

   // Next-state and registered-output logic for the IDLE / WAIT_MEM controller.
   always_comb begin
      state_d    = state_q;
      ld_rd_d    = ld_rd_q;
      ld_we_d    = ld_we_q;
      ld_fn3_d   = ld_fn3_q;
      ld_off_d   = ld_off_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      retire_d   = 1'b0;
      // A response with no load outstanding is flagged and otherwise ignored.
      err_d      = err_q | (dmem_rvalid && (state_q == IDLE));
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (in_wb_src == SRC_MEM) begin
                  // Loads to x0 still wait so that their response is consumed.
                  ld_rd_d  = in_rd;
                  ld_we_d  = in_reg_write;
                  ld_fn3_d = in_funct3;
                  ld_off_d = in_alu_result[OFF_W-1:0];
                  state_d  = WAIT_MEM;
               end else begin
                  retire_d = 1'b1;
                  rf_we_d  = in_reg_write && (in_rd != 5'd0);
                  if (rf_we_d) begin
                     rf_waddr_d = in_rd;
                     rf_wdata_d = src_data;
                  end
               end
            end
         end
         WAIT_MEM: begin
            if (dmem_rvalid) begin
               retire_d = 1'b1;
               rf_we_d  = ld_we_q && (ld_rd_q != 5'd0);
               if (rf_we_d) begin
                  rf_waddr_d = ld_rd_q;
                  rf_wdata_d = load_data;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // The count advances together with the retire pulse it accounts for.
      cnt_d = cnt_q + CNT_W'(retire_d);
   end

   // State and output registers; reset drops any pending load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ld_rd_q    <= '0;
         ld_we_q    <= 1'b0;
         ld_fn3_q   <= '0;
         ld_off_q   <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         retire_q   <= 1'b0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ld_rd_q    <= ld_rd_d;
         ld_we_q    <= ld_we_d;
         ld_fn3_q   <= ld_fn3_d;
         ld_off_q   <= ld_off_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         retire_q   <= retire_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

endmodule
